inst_prefetch_queue: RTL and testbench

Parametrised instruction prefetch queue for the PANZER16 front end, successor to the single-width instruction manager. After a redirect (`Set`), it fetches sequential instruction words over the ROM-side bus handshake (`Trans`/`PReady`) into a DEPTH-entry FIFO. It presents the head entry to decode, and it cleanly discards an in-flight response when redirected mid-transaction.

---
 rtl/inst_prefetch_queue.sv | 163 ++++++++++++++++
 tb/tb_inst_prefetch_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words into a DEPTH-entry FIFO after a redirect.
// Optional feature macro: IPQ_HEADADDR_EN adds per-entry fetch address storage and the HeadAddr port.
//
// state   | meaning
// IDLE    | no bus request; waits for Armed and free space
// FETCH   | request at FetchAddr; captures PDataIn on PReady
// DISCARD | request abandoned by a redirect; its response is dropped
module inst_prefetch_queue #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 4,
  parameter int ADDR_STEP = 1
) (
  input  logic              Clk,
  input  logic              RST,
  input  logic              Set,
  input  logic [ADDR_W-1:0] AddrIn,
  input  logic              Dequeue,
  input  logic              PReady,
  input  logic [DATA_W-1:0] PDataIn,
  output logic              Trans,
  output logic [ADDR_W-1:0] AddressOut,
  output logic [DATA_W-1:0] InstructionOut,
  output logic              Empty,
  output logic              Full,
  output logic              Busy
`ifdef IPQ_HEADADDR_EN
  ,
  output logic [ADDR_W-1:0] HeadAddr
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] disc_addr_q, disc_addr_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
`ifdef IPQ_HEADADDR_EN
  logic [ADDR_W-1:0] amem_q [DEPTH];
  logic [ADDR_W-1:0] amem_d [DEPTH];
`endif

  logic wr_en;
  logic deq_en;

  // State register
  always_ff @(posedge Clk) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (Set || (armed_q && count_q != FULL_CNT)) state_d = FETCH;
      end
      FETCH: begin
        if (Set)                                state_d = PReady ? FETCH : DISCARD;
        else if (PReady && count_d == FULL_CNT) state_d = IDLE;
      end
      DISCARD: begin
        if (PReady) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: queue status comes from registered count only
  always_comb begin
    Trans          = (state_q != IDLE);
    Busy           = Trans;
    AddressOut     = '0;
    if (state_q == FETCH)   AddressOut = fetch_addr_q;
    if (state_q == DISCARD) AddressOut = disc_addr_q;
    Empty          = (count_q == '0);
    Full           = (count_q == FULL_CNT);
    InstructionOut = Empty ? '0 : mem_q[head_q];
`ifdef IPQ_HEADADDR_EN
    HeadAddr       = Empty ? '0 : amem_q[head_q];
`endif
  end

  // Queue and fetch-address datapath
  always_comb begin
    wr_en        = (state_q == FETCH) && PReady && !Set;
    deq_en       = Dequeue && (count_q != '0) && !Set;
    armed_d      = armed_q;
    fetch_addr_d = fetch_addr_q;
    disc_addr_d  = disc_addr_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    mem_d        = mem_q;
`ifdef IPQ_HEADADDR_EN
    amem_d       = amem_q;
`endif
    if (Set) begin
      armed_d      = 1'b1;
      fetch_addr_d = AddrIn;
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      // Remember the abandoned address so the bus sees it held until its response
      if (state_q == FETCH && !PReady) disc_addr_d = fetch_addr_q;
    end else begin
      if (wr_en) begin
        mem_d[tail_q] = PDataIn;
`ifdef IPQ_HEADADDR_EN
        amem_d[tail_q] = fetch_addr_q;
`endif
        tail_d       = tail_q + PTR_W'(1);
        fetch_addr_d = fetch_addr_q + STEP;
      end
      if (deq_en) head_d = head_q + PTR_W'(1);
      if (wr_en && !deq_en)      count_d = count_q + CNT_W'(1);
      else if (!wr_en && deq_en) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      armed_q      <= 1'b0;
      fetch_addr_q <= '0;
      disc_addr_q  <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      armed_q      <= armed_d;
      fetch_addr_q <= fetch_addr_d;
      disc_addr_q  <= disc_addr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

  // Entry storage needs no reset; it is masked by the count when empty
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
`ifdef IPQ_HEADADDR_EN
    amem_q <= amem_d;
`endif
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: directed vector table, corner sequences and random stimulus
// checked against a queue-based reference model. Define IPQ_HEADADDR_EN to cover HeadAddr.
module tb_inst_prefetch_queue;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          Clk = 1'b0;
  logic          RST = 1'b1;
  logic          Set = 1'b0;
  logic [AW-1:0] AddrIn = '0;
  logic          Dequeue = 1'b0;
  logic          PReady = 1'b0;
  logic [DW-1:0] PDataIn = '0;
  logic          Trans;
  logic [AW-1:0] AddressOut;
  logic [DW-1:0] InstructionOut;
  logic          Empty;
  logic          Full;
  logic          Busy;
`ifdef IPQ_HEADADDR_EN
  logic [AW-1:0] HeadAddr;
`endif

  inst_prefetch_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ADDR_STEP(1)) dut (
    .Clk(Clk), .RST(RST), .Set(Set), .AddrIn(AddrIn), .Dequeue(Dequeue),
    .PReady(PReady), .PDataIn(PDataIn), .Trans(Trans), .AddressOut(AddressOut),
    .InstructionOut(InstructionOut), .Empty(Empty), .Full(Full), .Busy(Busy)
`ifdef IPQ_HEADADDR_EN
    , .HeadAddr(HeadAddr)
`endif
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a pending bus request plus a plain queue of captured words
  bit            m_armed = 0;
  bit            m_act   = 0;
  bit            m_disc  = 0;
  logic [AW-1:0] m_fa    = '0;
  logic [AW-1:0] m_ra    = '0;
  logic [DW-1:0] m_q[$];
  logic [AW-1:0] m_qa[$];

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int   pre;
    logic done;
    if (RST) begin
      m_armed = 0; m_act = 0; m_disc = 0; m_fa = '0; m_ra = '0;
      m_q.delete(); m_qa.delete();
    end else begin
      pre  = m_q.size();
      done = m_act && PReady;
      if (Set) begin
        m_q.delete(); m_qa.delete();
        m_armed = 1;
        m_fa    = AddrIn;
        if (m_act && !PReady) m_disc = 1;
        else begin m_act = 1; m_disc = 0; m_ra = AddrIn; end
      end else begin
        if (Dequeue && pre > 0) begin
          void'(m_q.pop_front());
          void'(m_qa.pop_front());
        end
        if (done) begin
          if (!m_disc) begin
            m_q.push_back(PDataIn);
            m_qa.push_back(m_ra);
            m_fa = m_fa + 16'd1;
          end
          m_disc = 0;
          if (m_q.size() < DEPTH) m_ra = m_fa;
          else m_act = 0;
        end else if (!m_act && m_armed && pre < DEPTH) begin
          m_act = 1;
          m_ra  = m_fa;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("m_trans", Trans, m_act);
    chk("m_busy", Busy, m_act);
    chk("m_addr", AddressOut, m_act ? m_ra : 16'h0);
    chk("m_empty", Empty, m_q.size() == 0);
    chk("m_full", Full, m_q.size() == DEPTH);
    chk("m_instr", InstructionOut, (m_q.size() > 0) ? m_q[0] : 16'h0);
`ifdef IPQ_HEADADDR_EN
    chk("m_headaddr", HeadAddr, (m_q.size() > 0) ? m_qa[0] : 16'h0);
`endif
  endtask

  task automatic drive(input logic rst, input logic set, input logic [AW-1:0] a,
                       input logic deq, input logic prdy);
    RST = rst; Set = set; AddrIn = a; Dequeue = deq; PReady = prdy;
    PDataIn = rom(m_ra);
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic          rst, set;
    logic [AW-1:0] addr;
    logic          deq, prdy;
    logic          e_trans;
    logic [AW-1:0] e_addr;
    logic          e_empty, e_full;
    logic [DW-1:0] e_instr;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // rst set addr deq prdy | trans addr empty full instr
    tbl[0]  = '{1'b1, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 16'h0};
    tbl[1]  = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 16'd0,  1'b1, 1'b0, 16'h0};
    tbl[2]  = '{1'b0, 1'b1, 16'd69, 1'b0, 1'b1, 1'b1, 16'd69, 1'b1, 1'b0, 16'h0};
    tbl[3]  = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b1, 1'b1, 16'd70, 1'b0, 1'b0, rom(16'd69)};
    tbl[4]  = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b1, 1'b1, 16'd71, 1'b0, 1'b0, rom(16'd69)};
    tbl[5]  = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b1, 1'b1, 16'd72, 1'b0, 1'b0, rom(16'd69)};
    tbl[6]  = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 16'd0,  1'b0, 1'b1, rom(16'd69)};
    tbl[7]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b1, 1'b0, 16'd0,  1'b0, 1'b0, rom(16'd70)};
    tbl[8]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b1, 1'b1, 16'd73, 1'b0, 1'b0, rom(16'd71)};
    tbl[9]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b1, 1'b1, 16'd74, 1'b0, 1'b0, rom(16'd72)};
    tbl[10] = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 1'b1, 16'd74, 1'b0, 1'b0, rom(16'd72)};

    #2;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, tbl[i].set, tbl[i].addr, tbl[i].deq, tbl[i].prdy);
      cycle();
      chk($sformatf("tbl%0d_trans", i), Trans, tbl[i].e_trans);
      chk($sformatf("tbl%0d_addr", i), AddressOut, tbl[i].e_addr);
      chk($sformatf("tbl%0d_empty", i), Empty, tbl[i].e_empty);
      chk($sformatf("tbl%0d_full", i), Full, tbl[i].e_full);
      chk($sformatf("tbl%0d_instr", i), InstructionOut, tbl[i].e_instr);
    end

    // Redirect while the request to 70 is pending
    drive(1, 0, 0, 0, 0);    cycle();
    drive(0, 1, 69, 0, 0);   cycle();
    drive(0, 0, 0, 0, 1);    cycle();
    chk("redir_pending70", AddressOut, 16'd70);
    drive(0, 0, 0, 0, 0);    cycle();
    drive(0, 1, 68, 0, 0);   cycle();
    chk("redir_hold70_a", AddressOut, 16'd70);
    chk("redir_flushed", Empty, 1'b1);
    drive(0, 0, 0, 0, 0);    cycle();
    chk("redir_hold70_b", AddressOut, 16'd70);
    drive(0, 0, 0, 0, 1);    cycle();
    chk("redir_next68", AddressOut, 16'd68);
    chk("redir_dropped", Empty, 1'b1);
    drive(0, 0, 0, 0, 1);    cycle();
    chk("redir_first", InstructionOut, rom(16'd68));

    // Address wrap at the top of the space
    drive(1, 0, 0, 0, 0);        cycle();
    drive(0, 1, 16'hFFFE, 0, 1); cycle();
    chk("wrap_a0", AddressOut, 16'hFFFE);
    drive(0, 0, 0, 0, 1);        cycle();
    chk("wrap_a1", AddressOut, 16'hFFFF);
    drive(0, 0, 0, 0, 1);        cycle();
    chk("wrap_a2", AddressOut, 16'h0000);
    drive(0, 0, 0, 0, 1);        cycle();
    chk("wrap_a3", AddressOut, 16'h0001);

    // Dequeue on empty, then Set together with Dequeue
    drive(1, 0, 0, 0, 0);   cycle();
    drive(0, 0, 0, 1, 0);   cycle();
    chk("deq_empty", Empty, 1'b1);
    drive(0, 1, 10, 0, 1);  cycle();
    drive(0, 0, 0, 0, 1);   cycle();
    drive(0, 0, 0, 0, 1);   cycle();
    chk("two_entries", InstructionOut, rom(16'd10));
    drive(0, 1, 20, 1, 1);  cycle();
    chk("set_deq_empty", Empty, 1'b1);
    chk("set_deq_addr", AddressOut, 16'd20);

`ifdef IPQ_HEADADDR_EN
    drive(1, 0, 0, 0, 0);   cycle();
    drive(0, 1, 69, 0, 1);  cycle();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 1); cycle(); end
    drive(0, 0, 0, 1, 1);   cycle();
    chk("head_after_deq", HeadAddr, 16'd70);
    drive(0, 0, 0, 0, 1);   cycle();
    chk("refetch_trans", Trans, 1'b1);
    drive(1, 0, 0, 0, 1);   cycle();
    chk("rst_trans", Trans, 1'b0);
    chk("rst_headaddr", HeadAddr, 16'd0);
`endif

    // Randomized traffic against the model
    drive(1, 0, 0, 0, 0);   cycle();
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFC + $urandom_range(0, 3)) : AW'($urandom);
      RST     = ($urandom_range(0, 99) == 0);
      Set     = ($urandom_range(0, 11) == 0);
      AddrIn  = a;
      Dequeue = ($urandom_range(0, 2) == 0);
      PReady  = ($urandom_range(0, 1) == 1);
      PDataIn = DW'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
